// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle integer execution unit with shift-add multiplier
module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [5:0]  cnt;
  logic        mul_neg;

  logic [31:0] op_res;
  logic        op_ovf;
  logic        op_known;
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [63:0] mul_sum;
  logic [63:0] mul_prod;

  // Single-cycle operation results and the multiplier's per-iteration arithmetic
  always_comb begin
    add_res  = a + b;
    sub_res  = a - b;
    op_res   = 32'd0;
    op_ovf   = 1'b0;
    op_known = 1'b1;
    case (control)
      4'b0000: op_res = a & b;
      4'b0001: op_res = a | b;
      4'b0010: begin
        op_res = add_res;
        op_ovf = (a[31] == b[31]) && (add_res[31] != a[31]);
      end
      4'b0011: op_res = a ^ b;
      4'b0100: op_res = add_res;
      4'b0101: op_res = sub_res;
      4'b0110: begin
        op_res = sub_res;
        op_ovf = (a[31] != b[31]) && (sub_res[31] != a[31]);
      end
      4'b0111: op_res = {31'd0, $signed(a) < $signed(b)};
      default: op_known = 1'b0;
    endcase
    // 0x80000000 negates to itself, which is its correct unsigned magnitude
    mag_a    = a[31] ? (~a + 32'd1) : a;
    mag_b    = b[31] ? (~b + 32'd1) : b;
    mul_sum  = acc + (mplier[0] ? mcand : 64'd0);
    mul_prod = mul_neg ? (~mul_sum + 64'd1) : mul_sum;
  end

  // Control FSM, multiplier sequencing and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 32'd0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      halted    <= 1'b0;
      mcand     <= 64'd0;
      mplier    <= 32'd0;
      acc       <= 64'd0;
      cnt       <= 6'd0;
      mul_neg   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (control == 4'b1000 || control == 4'b1001) begin
              mcand    <= {32'd0, control[0] ? a : mag_a};
              mplier   <= control[0] ? b : mag_b;
              acc      <= 64'd0;
              cnt      <= 6'd0;
              mul_neg  <= ~control[0] & (a[31] ^ b[31]);
              state    <= S_MUL;
              in_ready <= 1'b0;
            end else if (control == 4'b1111) begin
              result    <= 32'd0;
              zero      <= 1'b1;
              overflow  <= 1'b0;
              out_valid <= 1'b1;
              halted    <= 1'b1;
              state     <= S_HALT;
              in_ready  <= 1'b0;
            end else begin
              result    <= op_res;
              zero      <= op_known && (op_res == 32'd0);
              overflow  <= op_ovf;
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            hi        <= mul_prod[63:32];
            lo        <= mul_prod[31:0];
            result    <= mul_prod[31:0];
            zero      <= (mul_prod[31:0] == 32'd0);
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_IDLE;
            in_ready  <= 1'b1;
          end
        end
        S_HALT: begin
          in_ready <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  control;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        halted;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic [31:0] last_res;

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .control(control), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .zero(zero), .overflow(overflow), .hi(hi), .lo(lo), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference semantics expressed with wide signed arithmetic
  task automatic model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output logic v);
    longint s;
    bit known;
    known = 1;
    v = 0;
    r = 0;
    case (c)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin
        s = longint'($signed(x)) + longint'($signed(y));
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: r = x ^ y;
      4'd4: r = x + y;
      4'd5: r = x - y;
      4'd6: begin
        s = longint'($signed(x)) - longint'($signed(y));
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: r = (longint'($signed(x)) < longint'($signed(y))) ? 32'd1 : 32'd0;
      default: known = 0;
    endcase
    z = known && (r == 32'd0);
  endtask

  task automatic mul_model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                           output logic [63:0] p);
    longint sp;
    logic [63:0] ux;
    logic [63:0] uy;
    if (c == 4'b1000) begin
      sp = longint'($signed(x)) * longint'($signed(y));
      p = sp;
    end else begin
      ux = {32'd0, x};
      uy = {32'd0, y};
      p = ux * uy;
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] r;
    logic z;
    logic v;
    model(c, x, y, r, z, v);
    in_valid = 1; control = c; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 0;
    chk({tag, ".out_valid"}, out_valid, 1'b1);
    chk({tag, ".result"}, result, r);
    chk({tag, ".zero"}, zero, z);
    chk({tag, ".overflow"}, overflow, v);
    chk({tag, ".hi"}, hi, exp_hi);
    last_res = r;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk({tag, ".idle_out_valid"}, out_valid, 1'b0);
    chk({tag, ".hold_result"}, result, last_res);
  endtask

  task automatic run_mul(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input bit poke, input string tag);
    logic [63:0] p;
    mul_model(c, x, y, p);
    in_valid = 1; control = c; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 0;
    chk({tag, ".busy0"}, in_ready, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      if (poke && (k == 3 || k == 17)) begin
        in_valid = 1; control = 4'b0010; a = 32'd1; b = 32'd1;
      end else begin
        in_valid = 0;
      end
      @(posedge clk); #1;
      chk({tag, ".busy_ready"}, in_ready, 1'b0);
      chk({tag, ".busy_valid"}, out_valid, 1'b0);
      if (k == 20) begin
        chk({tag, ".hi_stable"}, hi, exp_hi);
        chk({tag, ".lo_stable"}, lo, exp_lo);
      end
    end
    in_valid = 0;
    @(posedge clk); #1;
    exp_hi = p[63:32];
    exp_lo = p[31:0];
    last_res = p[31:0];
    chk({tag, ".done_valid"}, out_valid, 1'b1);
    chk({tag, ".hi"}, hi, exp_hi);
    chk({tag, ".lo"}, lo, exp_lo);
    chk({tag, ".result"}, result, exp_lo);
    chk({tag, ".zero"}, zero, exp_lo == 32'd0);
    chk({tag, ".overflow"}, overflow, 1'b0);
    chk({tag, ".ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] rx;
    logic [31:0] ry;
    reset = 1; in_valid = 0; control = 0; a = 0; b = 0;
    last_res = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.result", result, 32'd0);
    chk("rst.zero", zero, 1'b0);
    chk("rst.overflow", overflow, 1'b0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    chk("rst.halted", halted, 1'b0);
    reset = 0;

    issue(4'b0010, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    chk("add_ovf.value", result, 32'h8000_0000);
    chk("add_ovf.flag", overflow, 1'b1);
    idle_check("add_ovf");
    issue(4'b0100, 32'h7FFF_FFFF, 32'd1, "addu");
    chk("addu.flag", overflow, 1'b0);
    idle_check("addu");

    run_mul(4'b1000, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg");
    chk("mult_neg.hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_neg.lo_const", lo, 32'hFFFF_FFF1);
    run_mul(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    chk("multu_max.hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_max.lo_const", lo, 32'h0000_0001);
    run_mul(4'b1000, 32'h8000_0000, 32'h8000_0000, 0, "mult_min");
    chk("mult_min.hi_const", hi, 32'h4000_0000);
    chk("mult_min.lo_const", lo, 32'd0);

    issue(4'b0110, 32'd5, 32'd5, "stream_sub");
    chk("stream_sub.zero1", zero, 1'b1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, "stream_slt");
    chk("stream_slt.one", result, 32'd1);
    issue(4'b0011, 32'h0000_F0F0, 32'h0000_FFFF, "stream_xor");
    chk("stream_xor.val", result, 32'h0000_0F0F);
    idle_check("stream_end");

    run_mul(4'b1001, 32'h0001_2345, 32'h0000_0100, 1, "mul_poke");
    idle_check("mul_poke_after");

    issue(4'b0110, 32'h8000_0000, 32'd1, "sub_ovf");
    chk("sub_ovf.flag", overflow, 1'b1);
    issue(4'b1010, 32'd0, 32'd0, "undef");
    chk("undef.zero0", zero, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom_range(0, 12));
      if (rc >= 4'd8) rc = rc + 4'd2;
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? rx : $urandom;
      issue(rc, rx, ry, "rand_op");
    end
    idle_check("rand_end");
    for (int i = 0; i < 4; i++) begin
      rc = (i % 2 == 0) ? 4'b1000 : 4'b1001;
      run_mul(rc, $urandom, $urandom, 0, "rand_mul");
    end

    in_valid = 1; control = 4'b1001; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_hi = 0; exp_lo = 0;
    chk("rst_mul.out_valid", out_valid, 1'b0);
    chk("rst_mul.hi", hi, 32'd0);
    chk("rst_mul.lo", lo, 32'd0);
    chk("rst_mul.in_ready", in_ready, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk("rst_mul.no_valid", out_valid, 1'b0);
    end
    issue(4'b0010, 32'd2, 32'd3, "post_rst_add");
    chk("post_rst_add.five", result, 32'd5);

    in_valid = 1; control = 4'b1111; a = 32'hDEAD; b = 32'hBEEF;
    @(posedge clk); #1;
    in_valid = 0;
    chk("brk.out_valid", out_valid, 1'b1);
    chk("brk.result", result, 32'd0);
    chk("brk.zero", zero, 1'b1);
    chk("brk.halted", halted, 1'b1);
    chk("brk.in_ready", in_ready, 1'b0);
    in_valid = 1; control = 4'b0010; a = 32'd7; b = 32'd8;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      chk("brk.stuck_ready", in_ready, 1'b0);
      chk("brk.stuck_valid", out_valid, 1'b0);
    end
    in_valid = 0;
    chk("brk.result_hold", result, 32'd0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("brk_rst.halted", halted, 1'b0);
    chk("brk_rst.in_ready", in_ready, 1'b1);
    issue(4'b0001, 32'h00F0, 32'h0F00, "post_brk_or");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
